instr_fetch_unit: RTL and testbench

Instruction fetch stage of the LEGv8 datapath: holds the PC and issues word fetches to instruction memory over a valid/ready request channel. It buffers returned instructions in a small in-order queue and presents them to decode over a valid/ready handshake. Decode feeds the queue head to the immediate sign extender and the control unit. Taken branches redirect fetch, which flushes the queue and discards any stale in-flight response.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, WAIT)
//   INSTR_W       : instruction word width
//   DEFAULT_PC_W  : default PC/address width
//   PC_STEP       : PC increment per fetched word
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam int INSTR_W      = 32;
  localparam int DEFAULT_PC_W = 64;
  localparam int PC_STEP      = 4;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue holding {instr, pc} pairs.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   push, push_instr/pc : enqueue one entry
//   pop                 : dequeue the head entry
//   flush               : empty the queue; overrides push and pop
//   head_instr, head_pc : registered head entry (zero after reset)
//   count               : occupied entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = DEFAULT_PC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [INSTR_W-1:0]     push_instr,
  input  logic [PC_W-1:0]        push_pc,
  input  logic                   pop,
  input  logic                   flush,
  output logic [INSTR_W-1:0]     head_instr,
  output logic [PC_W-1:0]        head_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  assign head_instr = instr_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
        instr_q[PTR_W'(i)] <= '0;
        pc_q[PTR_W'(i)]    <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        instr_q[wr_ptr] <= push_instr;
        pc_q[wr_ptr]    <= push_pc;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction fetch stage: PC register, single-outstanding fetch
// FSM on a valid/ready memory channel, and an in-order instruction queue
// presented to decode over valid/ready. A taken branch flushes the queue,
// reloads the PC and drops any stale in-flight response.
//   CLK, Reset, StartPC              : clock, sync active-high reset, reset PC
//   IMemReqValid/Ready, IMemAddr     : fetch request channel
//   IMemRspValid, IMemRspData        : fetch response (one per accepted request)
//   InstrValid/Ready, Imm32, InstrPC : queue head to decode
//   Redirect, RedirectPC             : branch redirect
//   QueueCount                       : occupied queue entries
// Optional macro FETCH_PERF_CNT_EN adds FetchCount and FlushCount outputs.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = DEFAULT_PC_W
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [PC_W-1:0]        StartPC,
  output logic                   IMemReqValid,
  input  logic                   IMemReqReady,
  output logic [PC_W-1:0]        IMemAddr,
  input  logic                   IMemRspValid,
  input  logic [INSTR_W-1:0]     IMemRspData,
  output logic                   InstrValid,
  input  logic                   InstrReady,
  output logic [INSTR_W-1:0]     Imm32,
  output logic [PC_W-1:0]        InstrPC,
  input  logic                   Redirect,
  input  logic [PC_W-1:0]        RedirectPC,
  output logic [$clog2(DEPTH):0] QueueCount
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            FetchCount,
  output logic [31:0]            FlushCount
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic            drop;
  logic            enq;
  logic            pop;
  logic            space_now;
  logic            space_after;
  logic [CNT_W:0]  occ_now;
  logic [CNT_W:0]  occ_after;
  logic [PC_W-1:0] redirect_aligned;

  assign IMemReqValid     = (state == REQ);
  assign IMemAddr         = pc;
  assign InstrValid       = (QueueCount != '0);
  assign pop              = InstrValid && InstrReady;
  assign redirect_aligned = RedirectPC & ~(PC_W'(PC_STEP - 1));

  // Response is kept only when it belongs to the current fetch stream.
  assign enq = (state == WAIT) && IMemRspValid && !drop && !Redirect;

  // The in-flight request reserves a slot so a response can never overflow.
  assign occ_now     = {1'b0, QueueCount} + {{CNT_W{1'b0}}, state == WAIT};
  assign space_now   = occ_now < (CNT_W+1)'(DEPTH);
  assign occ_after   = {1'b0, QueueCount} + (CNT_W+1)'(1) - {{CNT_W{1'b0}}, pop};
  assign space_after = occ_after < (CNT_W+1)'(DEPTH);

  fetch_queue #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_queue (
    .clk        (CLK),
    .reset      (Reset),
    .push       (enq),
    .push_instr (IMemRspData),
    .push_pc    (req_pc),
    .pop        (pop),
    .flush      (Redirect),
    .head_instr (Imm32),
    .head_pc    (InstrPC),
    .count      (QueueCount)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      pc     <= StartPC;
      req_pc <= '0;
      drop   <= 1'b0;
    end else if (Redirect) begin
      pc <= redirect_aligned;
      case (state)
        REQ: begin
          // An accepted request still owes a response; mark it stale.
          if (IMemReqReady) begin
            state <= WAIT;
            drop  <= 1'b1;
          end
        end
        WAIT: begin
          if (IMemRspValid) begin
            state <= REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (space_now) state <= REQ;
        end
        REQ: begin
          if (IMemReqReady) begin
            pc     <= pc + PC_W'(PC_STEP);
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (IMemRspValid) begin
            drop  <= 1'b0;
            state <= (drop || space_after) ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_rsp_when_full : assert property (
    @(posedge CLK) disable iff (Reset)
    !(enq && (QueueCount == CNT_W'(DEPTH)))
  );

`ifdef FETCH_PERF_CNT_EN
  logic rsp_discard;

  assign rsp_discard = (state == WAIT) && IMemRspValid && (drop || Redirect);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      FetchCount <= '0;
      FlushCount <= '0;
    end else begin
      if (enq) FetchCount <= FetchCount + 32'd1;
      FlushCount <= FlushCount
                  + (Redirect ? 32'(QueueCount) : 32'd0)
                  + {31'd0, rsp_discard};
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [PC_W-1:0] StartPC;
  logic            IMemReqValid;
  logic            IMemReqReady;
  logic [PC_W-1:0] IMemAddr;
  logic            IMemRspValid;
  logic [31:0]     IMemRspData;
  logic            InstrValid;
  logic            InstrReady;
  logic [31:0]     Imm32;
  logic [PC_W-1:0] InstrPC;
  logic            Redirect;
  logic [PC_W-1:0] RedirectPC;
  logic [$clog2(DEPTH):0] QueueCount;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     FetchCount;
  logic [31:0]     FlushCount;
`endif

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .StartPC      (StartPC),
    .IMemReqValid (IMemReqValid),
    .IMemReqReady (IMemReqReady),
    .IMemAddr     (IMemAddr),
    .IMemRspValid (IMemRspValid),
    .IMemRspData  (IMemRspData),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Imm32        (Imm32),
    .InstrPC      (InstrPC),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .QueueCount   (QueueCount)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount   (FetchCount),
    .FlushCount   (FlushCount)
`endif
  );

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t sb[$];

  int n_total = 0;
  int n_bad   = 0;

  // memory model: one slot, response after lat cycles
  logic            pend = 1'b0;
  logic            pend_stale = 1'b0;
  logic [PC_W-1:0] pend_addr = '0;
  int              pend_cnt = 0;
  int              lat = 1;
  logic            rsp_stale = 1'b0;
  logic [PC_W-1:0] rsp_addr = '0;

  logic [PC_W-1:0] exp_pc;
  logic [PC_W-1:0] last_hs_addr;
  int              cyc, hs_cnt, pops, pushes, dropped_total;
  int              first_req, first_valid;
  logic            dropped_now;
  logic            ok;

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with this cycle's inputs final; scores the cycle,
  // advances one clock and drives the memory response for the next cycle.
  task automatic cycle();
    entry_t e;
    dropped_now = 1'b0;
    if (!Reset) begin
      if (IMemReqValid && first_req < 0) first_req = cyc;
      if (InstrValid && first_valid < 0) first_valid = cyc;
      if (InstrValid && InstrReady && !Redirect) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("imm32", {32'd0, Imm32}, {32'd0, e.instr});
          check("instr_pc", InstrPC, e.pc);
          pops++;
        end
      end
      if (IMemRspValid) begin
        if (Redirect || rsp_stale) begin
          dropped_now = 1'b1;
          dropped_total++;
        end else begin
          e.instr = mem_word(rsp_addr);
          e.pc    = rsp_addr;
          sb.push_back(e);
          pushes++;
        end
      end
      if (Redirect) begin
        sb.delete();
        if (pend) pend_stale = 1'b1;
      end
      if (IMemReqValid && IMemReqReady) begin
        check("req_addr", IMemAddr, exp_pc);
        if (pend || IMemRspValid) check("one_outstanding", 64'd1, 64'd0);
        exp_pc       = exp_pc + 64'd4;
        pend         = 1'b1;
        pend_addr    = IMemAddr;
        pend_cnt     = lat;
        pend_stale   = Redirect;
        last_hs_addr = IMemAddr;
        hs_cnt++;
      end
      if (Redirect) exp_pc = {RedirectPC[PC_W-1:2], 2'b00};
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    IMemRspValid = 1'b0;
    IMemRspData  = '0;
    if (Reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pend_cnt <= 1) begin
        IMemRspValid = 1'b1;
        IMemRspData  = mem_word(pend_addr);
        rsp_addr     = pend_addr;
        rsp_stale    = pend_stale;
        pend         = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic do_reset(input logic rdy);
    Reset        = 1'b1;
    Redirect     = 1'b0;
    RedirectPC   = '0;
    InstrReady   = rdy;
    IMemReqReady = 1'b1;
    lat          = 1;
    cycle();
    cycle();
    check("rst_reqvalid", {63'd0, IMemReqValid}, 64'd0);
    check("rst_addr", IMemAddr, StartPC);
    check("rst_instrvalid", {63'd0, InstrValid}, 64'd0);
    check("rst_imm32", {32'd0, Imm32}, 64'd0);
    check("rst_instrpc", InstrPC, 64'd0);
    check("rst_count", 64'(QueueCount), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetchcnt", {32'd0, FetchCount}, 64'd0);
    check("rst_flushcnt", {32'd0, FlushCount}, 64'd0);
`endif
    sb.delete();
    pend = 1'b0; pend_stale = 1'b0; rsp_stale = 1'b0;
    exp_pc = StartPC;
    hs_cnt = 0; pops = 0; pushes = 0; dropped_total = 0;
    first_req = -1; first_valid = -1;
    Reset = 1'b0;
    cyc = 1;
  endtask

  initial begin
    Reset = 1'b1; StartPC = 64'h1000; Redirect = 1'b0; RedirectPC = '0;
    InstrReady = 1'b1; IMemReqReady = 1'b1; IMemRspValid = 1'b0; IMemRspData = '0;

    // in-order fetch, first-request / first-valid latency, 1 per 2 cycles
    do_reset(1'b1);
    repeat (24) cycle();
    check("t1_first_req_cycle", 64'(first_req), 64'd2);
    check("t1_first_valid_cycle", 64'(first_valid), 64'd4);
    check("t1_handshakes", 64'(hs_cnt), 64'd12);
    check("t1_pops", 64'(pops), 64'd11);
    check("t1_sb_vs_count", 64'(QueueCount), 64'(sb.size()));

    // decode stalled: queue fills to DEPTH and fetch stops
    do_reset(1'b0);
    repeat (20) cycle();
    check("t2_handshakes", 64'(hs_cnt), 64'd4);
    check("t2_count", 64'(QueueCount), 64'd4);
    check("t2_reqvalid", {63'd0, IMemReqValid}, 64'd0);
    InstrReady = 1'b1;
    repeat (20) cycle();
    check("t2_pops", 64'(pops >= 8), 64'd1);
    check("t2_sb_vs_count", 64'(QueueCount), 64'(sb.size()));

    // redirect in WAIT with a slow response
    do_reset(1'b0);
    lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      ok = (QueueCount == 2) && pend && !IMemRspValid;
      if (!ok) cycle();
    end
    check("t3_reach_wait", {63'd0, ok}, 64'd1);
    Redirect = 1'b1; RedirectPC = 64'h2003;
    cycle();
    Redirect = 1'b0; RedirectPC = '0;
    check("t3_count_flushed", 64'(QueueCount), 64'd0);
    check("t3_no_req_while_drop", {63'd0, IMemReqValid}, 64'd0);
    InstrReady = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 20 && hs_cnt == 0; i++) cycle();
    check("t3_first_addr", last_hs_addr, 64'h2000);
    check("t3_dropped", 64'(dropped_total), 64'd1);
    repeat (16) cycle();
    check("t3_sb_vs_count", 64'(QueueCount), 64'(sb.size()));

    // redirect together with a response and a dequeue
    do_reset(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      ok = IMemRspValid && InstrValid;
      if (!ok) cycle();
    end
    check("t4_reach_rsp", {63'd0, ok}, 64'd1);
    Redirect = 1'b1; RedirectPC = 64'h3000; InstrReady = 1'b1;
    cycle();
    Redirect = 1'b0; RedirectPC = '0;
    check("t4_count", 64'(QueueCount), 64'd0);
    check("t4_instrvalid", {63'd0, InstrValid}, 64'd0);
    check("t4_reqvalid", {63'd0, IMemReqValid}, 64'd1);
    check("t4_addr", IMemAddr, 64'h3000);
    check("t4_dropped", 64'(dropped_total), 64'd1);
    repeat (12) cycle();
    check("t4_sb_vs_count", 64'(QueueCount), 64'(sb.size()));

    // memory not ready: address held, then redirect without handshake
    do_reset(1'b1);
    IMemReqReady = 1'b0;
    for (int i = 0; i < 10 && !IMemReqValid; i++) cycle();
    check("t5_reqvalid", {63'd0, IMemReqValid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_addr_hold", IMemAddr, 64'h1000);
    end
    check("t5_no_handshake", 64'(hs_cnt), 64'd0);
    Redirect = 1'b1; RedirectPC = 64'h4000;
    cycle();
    Redirect = 1'b0; RedirectPC = '0;
    check("t5_redirect_addr", IMemAddr, 64'h4000);
    check("t5_redirect_valid", {63'd0, IMemReqValid}, 64'd1);
    IMemReqReady = 1'b1;
    repeat (6) cycle();
    check("t5_handshakes", 64'(hs_cnt), 64'd3);
    check("t5_last_addr", last_hs_addr, 64'h4008);

`ifdef FETCH_PERF_CNT_EN
    // 10 fetches, then redirect with 3 queued and 1 in flight
    do_reset(1'b1);
    lat = 2;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = (pops >= 7) && (QueueCount == 3) && pend && !IMemRspValid;
      if (!ok) begin
        InstrReady = (pops < 7);
        cycle();
      end
    end
    check("t6_reach", {63'd0, ok}, 64'd1);
    Redirect = 1'b1; RedirectPC = 64'h5000;
    cycle();
    Redirect = 1'b0; RedirectPC = '0;
    check("t6_fetchcnt_a", {32'd0, FetchCount}, 64'd10);
    check("t6_flushcnt_a", {32'd0, FlushCount}, 64'd3);
    for (int i = 0; i < 10 && !dropped_now; i++) cycle();
    check("t6_drop_seen", {63'd0, dropped_now}, 64'd1);
    check("t6_fetchcnt_b", {32'd0, FetchCount}, 64'd10);
    check("t6_flushcnt_b", {32'd0, FlushCount}, 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
